// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared UART state encoding, frame size and baud helper.
// Revision 1.0
// ------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int BIT_NUM = 8;

  function automatic int calc_baud_end(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_baud_gen : per-bit clock counter, pulses bit_end on the last clock
// of each bit while enabled. Revision 1.0
// ------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic sclk_50M,
  input  logic s_rst_n,
  input  logic enable,
  output logic bit_end
);

  localparam int BAUD_END = calc_baud_end(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = $clog2(BAUD_END + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BAUD_END);

  generate
    if (BAUD_END < 1) begin : g_baud_guard
      $error("uart_baud_gen: BAUD_END must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0] baud_cnt;

  // Count is held at zero while disabled so every bit starts aligned.
  always_ff @(posedge sclk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      baud_cnt <= '0;
    end else if (!enable || baud_cnt == CNT_END) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  assign bit_end = enable && (baud_cnt == CNT_END);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter, LSB first; optional parity bit when
// UART_TX_PARITY_EN is defined (PARITY_ODD selects odd). Revision 1.0
// ------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       sclk_50M,
  input  logic       s_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(BIT_NUM - 1);

  state_t     state, state_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       tx_nxt;
  logic       accept;
  logic       bit_end;
`ifdef UART_TX_PARITY_EN
  logic       par_bit, par_nxt;
`endif

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_baud_gen (
    .sclk_50M(sclk_50M),
    .s_rst_n (s_rst_n),
    .enable  (state != IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = 1'b1;
    accept      = tx_valid && tx_ready;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par_bit;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = START;
          shift_nxt   = tx_data;
          bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          par_nxt     = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      START: if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end) begin
          shift_nxt   = {1'b0, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP: if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // tx is derived from the upcoming state, so it only moves on bit boundaries.
    case (state_nxt)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sclk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx       <= tx_nxt;
      tx_ready <= (state_nxt == IDLE);
      tx_busy  <= (state_nxt != IDLE);
      tx_done  <= (state == STOP) && bit_end;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_nxt;
`endif
    end
  end

endmodule
`default_nettype wire
